// File: rtl/seq_arith_nbit_add_carry_digit.sv
// Digit-serial adder: in0 + in1 + cin over NBITS/DBITS cycles, LSB digit first,
// behind val/rdy handshakes. Reports unsigned carry-out and signed overflow.
module seq_arith_nbit_add_carry_digit #(
  parameter int NBITS = 8,
  parameter int DBITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             cin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEPS = NBITS / DBITS;
  localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q;
  logic [NBITS-1:0] a_q, b_q, sum_q, out_q;
  logic             a_msb_q, b_msb_q, carry_q, cout_q, ovf_q;
  logic [SW-1:0]    step_q;
  logic [DBITS:0]   slice_sum;
  logic [NBITS-1:0] sum_d;

  // Operands shift right each step so the active digit is always at bit 0;
  // the sum fills from the top so it is aligned after the last step.
  assign slice_sum = {1'b0, a_q[DBITS-1:0]} + {1'b0, b_q[DBITS-1:0]}
                   + {{DBITS{1'b0}}, carry_q};
  assign sum_d     = (sum_q >> DBITS)
                   | (NBITS'(slice_sum[DBITS-1:0]) << (NBITS - DBITS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_val) begin
          a_q     <= in0;
          b_q     <= in1;
          a_msb_q <= in0[NBITS-1];
          b_msb_q <= in1[NBITS-1];
          carry_q <= cin;
          sum_q   <= '0;
          step_q  <= '0;
          state_q <= CALC;
        end
        CALC: begin
          a_q     <= a_q >> DBITS;
          b_q     <= b_q >> DBITS;
          sum_q   <= sum_d;
          carry_q <= slice_sum[DBITS];
          step_q  <= step_q + 1'b1;
          if (step_q == STEP_LAST) begin
            // Visible result only changes here, never with partial sums.
            out_q   <= sum_d;
            cout_q  <= slice_sum[DBITS];
            ovf_q   <= (a_msb_q == b_msb_q) && (sum_d[NBITS-1] != a_msb_q);
            state_q <= DONE;
          end
        end
        DONE: if (out_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rdy  = reset && (state_q == IDLE);
  assign out_val = (state_q == DONE);
  assign out     = out_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/seq_arith_nbit_add_carry_digit.md
Name: seq_arith_nbit_add_carry_digit

Overview:
Multi-cycle digit-serial adder. It computes out = in0 + in1 + cin over NBITS/DBITS cycles, processing DBITS bits per cycle from the LSB upward. It also reports unsigned carry-out and signed overflow. It sits behind val/rdy interfaces so it can replace the single-cycle 8b combinational add-with-carry where area matters and latency is tolerable.

Parameters:
NBITS, 8, operand/result width; must be >= 1.
DBITS, 1, bits added per cycle; must be >= 1, <= NBITS, and NBITS % DBITS == 0.
NSTEPS (derived, not overridable), NBITS/DBITS, number of CALC cycles.

Ports:
clk      input   1      clock; all state updates on the rising edge
reset    input   1      asynchronous, active-low reset
in_val   input   1      operands valid
in_rdy   output  1      block can accept operands
in0      input   NBITS  operand 0
in1      input   NBITS  operand 1
cin      input   1      carry-in
out_val  output  1      result valid
out_rdy  input   1      consumer accepts result
out      output  NBITS  sum, modulo 2^NBITS
cout     output  1      unsigned carry-out of the MSB
ovf      output  1      signed (two's complement) overflow

Behaviour:
- Reset (reset == 0, asynchronous): state = IDLE, out = 0, cout = 0, ovf = 0, out_val = 0, step counter = 0, internal carry = 0. While reset is low, in_rdy = 0 and in_val is ignored.
- Reset asserted mid-operation (CALC or DONE) aborts the operation. No result is produced, and the operands are discarded.
- State machine:
  - IDLE: in_rdy = 1, out_val = 0. On in_val && in_rdy, latch in0, in1, cin, load internal carry = cin, step = 0, go to CALC.
  - CALC: in_rdy = 0, out_val = 0. Each cycle adds slice [step*DBITS +: DBITS] of both operands plus the carry register, stores the slice sum, updates carry, then increments step. After NSTEPS CALC cycles, go to DONE.
  - DONE: in_rdy = 0, out_val = 1. On out_val && out_rdy, go to IDLE.
- Latency: operands accepted at edge E0 -> out_val high from edge E0+NSTEPS. Examples: NBITS=8, DBITS=1 -> 8 cycles; DBITS=NBITS -> 1 cycle.
- Throughput: the block is not pipelined. DONE->IDLE takes one edge, and IDLE accepts on the next edge. Peak rate is one operation per NSTEPS+2 cycles.
- Output update rule: out, cout and ovf update only on the edge entering DONE. They hold that value through DONE and afterwards, until the next entry to DONE. Partial sums are never visible on out.
- Result rules:
  - {cout, out} = in0 + in1 + cin, computed at NBITS+1 width.
  - ovf = (in0[MSB] == in1[MSB]) && (out[MSB] != in0[MSB]), using latched operands.
- Backpressure: while in DONE with out_rdy = 0, out_val, out, cout and ovf are held stable. in_val pulses during CALC/DONE are ignored, not queued.
- Inputs in0/in1/cin may change freely after acceptance; only the latched copies are used.
- Simultaneous in_val and out_rdy in the same cycle have no interaction, because in_rdy and out_val are never both 1.
- No X on any output after reset.

Test Plan:
- Default params. Accept 42 + 13, cin=0 at edge E0 -> out_val rises at E0+8, out=0x37, cout=0, ovf=0. in_rdy is 0 from E0 until the handshake completes.
- Default params. Check each case in turn:
  - 127 + 1, cin=0 -> out=0x80, cout=0, ovf=1.
  - 0xFF + 0x00, cin=1 -> out=0x00, cout=1, ovf=0.
  - 0x80 + 0xFF, cin=0 -> out=0x7F, cout=1, ovf=1.
  - 0xD6 + 0xF3, cin=1 -> out=0xCA, cout=1, ovf=0.
- Backpressure. Hold out_rdy=0 for 5 cycles in DONE, pulsing in_val with new operands -> out_val stays 1, out/cout/ovf unchanged, new operands not accepted. Raise out_rdy -> IDLE next edge, in_rdy=1.
- Back-to-back. in_val and out_rdy held high with 3 operand sets -> acceptances exactly NSTEPS+2 = 10 cycles apart, results in order. Scoreboard against an NBITS+1-bit reference add.
- Reset mid-CALC. Drop reset at step 3 of 8 -> out_val=0, out=0, cout=0, ovf=0 immediately. After release, in_rdy=1, and a fresh 1 + 0, cin=0 yields out=0x01.
- Parameter sweep with NBITS=16, DBITS=4 (4 CALC cycles) and NBITS=8, DBITS=8 (1 CALC cycle):
  - 0xFFFF + 0x0001, cin=0 -> out=0x0000, cout=1, ovf=0.
  - 100 + 26, cin=1 -> out=127 with 1-cycle latency.
  - Follow with 20 random operand/cin sets per configuration, checked against the reference sum.
